// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// controller states and the iteration count.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply step or
// restoring-divide step, both built around a single 33-bit add/subtract.
module muldiv_step (
    input  logic        mode_div,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic [31:0] opnd_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [32:0] a;
    logic [32:0] b;
    logic [33:0] s;
    logic        ge;

    always_comb begin
        a    = mode_div ? {hi_i, lo_i[31]} : {1'b0, hi_i};
        b    = (mode_div || lo_i[0]) ? {1'b0, opnd_i} : 33'd0;
        s    = mode_div ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
        ge   = ~s[33];
        hi_o = s[32:1];
        lo_o = {s[0], lo_i[31:1]};
        if (mode_div) begin
            // Partial remainder stays below the divisor, so 32 bits suffice.
            hi_o = ge ? s[31:0] : a[31:0];
            lo_o = {lo_i[30:0], ge};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MIPS-style mult/multu/div/divu unit owning the HI/LO registers,
// with mthi/mtlo writes and a stall output for requesters colliding with it.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] Read_data_1,
    input  logic [31:0] Read_data_2,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic        hilo_rd,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam logic [5:0] ITER_LAST = 6'(MD_ITER - 1);

    md_state_e   state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] opnd_q, opnd_d;
    logic [31:0] acc_hi_q, acc_hi_d;
    logic [31:0] acc_lo_q, acc_lo_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    logic [31:0] dvd_q, dvd_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        sgn_op, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [31:0] step_hi, step_lo;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    assign sgn_op = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg  = sgn_op & Read_data_1[31];
    assign b_neg  = sgn_op & Read_data_2[31];
    assign a_mag  = a_neg ? -Read_data_1 : Read_data_1;
    assign b_mag  = b_neg ? -Read_data_2 : Read_data_2;

    assign prod_fix = neg_res_q ? -{acc_hi_q, acc_lo_q} : {acc_hi_q, acc_lo_q};
    assign quo_fix  = neg_res_q ? -acc_lo_q : acc_lo_q;
    assign rem_fix  = neg_rem_q ? -acc_hi_q : acc_hi_q;

    muldiv_step u_step (
        .mode_div (op_q[1]),
        .hi_i     (acc_hi_q),
        .lo_i     (acc_lo_q),
        .opnd_i   (opnd_q),
        .hi_o     (step_hi),
        .lo_o     (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        opnd_d    = opnd_q;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        dvd_d     = dvd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    cnt_d     = '0;
                    op_d      = op;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = op[1] && (Read_data_2 == '0);
                    dvd_d     = Read_data_1;
                    acc_hi_d  = '0;
                    // lo accumulator seeds with the operand that gets shifted out.
                    acc_lo_d  = op[1] ? a_mag : b_mag;
                    opnd_d    = op[1] ? b_mag : a_mag;
                end
            end
            S_RUN: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == ITER_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_DONE;
                if (!op_q[1]) begin
                    hi_d = prod_fix[63:32];
                    lo_d = prod_fix[31:0];
                end else if (div0_q) begin
                    hi_d = dvd_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (hilo_we && (state_q == S_IDLE)) begin
            if (hilo_sel) hi_d = Read_data_1;
            else          lo_d = Read_data_1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            opnd_q    <= '0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            dvd_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            opnd_q    <= opnd_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            dvd_q     <= dvd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign Hi    = hi_q;
    assign Lo    = lo_q;
    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign stall = busy & (start | hilo_rd | hilo_we);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: cycle-count reference model checked every cycle,
// plus directed vectors with hand-computed HI/LO results and latencies.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rd1 = '0;
    logic [31:0] rd2 = '0;
    logic        hilo_we = 1'b0;
    logic        hilo_sel = 1'b0;
    logic        hilo_rd = 1'b0;
    logic [31:0] Hi, Lo;
    logic        busy, done, stall;

    int checks = 0;
    int errors = 0;

    muldiv_ctrl dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .Read_data_1 (rd1),
        .Read_data_2 (rd2),
        .hilo_we     (hilo_we),
        .hilo_sel    (hilo_sel),
        .hilo_rd     (hilo_rd),
        .Hi          (Hi),
        .Lo          (Lo),
        .busy        (busy),
        .done        (done),
        .stall       (stall)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural result {HI,LO} from plain integer arithmetic.
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb;
        logic [63:0] q, r, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            MD_MULT: begin
                p = sa * sb;
                return p;
            end
            MD_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                return p;
            end
            MD_DIV: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    // Model: m_cnt counts cycles since acceptance (0 = idle), result lands on the 33rd edge.
    int          m_cnt = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [63:0] m_pend = '0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
        end else if (m_cnt == 0) begin
            if (hilo_we && hilo_sel)  m_hi <= rd1;
            if (hilo_we && !hilo_sel) m_lo <= rd1;
            if (start) begin
                m_pend <= ref_result(op, rd1, rd2);
                m_cnt  <= 1;
            end
        end else begin
            if (m_cnt == 33) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
            m_cnt <= (m_cnt == 34) ? 0 : m_cnt + 1;
        end
    end

    always @(negedge clock) begin
        chk("busy",  {63'd0, busy},  {63'd0, m_cnt != 0});
        chk("done",  {63'd0, done},  {63'd0, m_cnt == 34});
        chk("stall", {63'd0, stall}, {63'd0, (m_cnt != 0) && (start || hilo_rd || hilo_we)});
        chk("hi",    {32'd0, Hi},    {32'd0, m_hi});
        chk("lo",    {32'd0, Lo},    {32'd0, m_lo});
    end

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        rd1   = a;
        rd2   = b;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Waits for done (bounded); operands are scrambled to prove they were latched.
    task automatic wait_done(input int hold, output int lat);
        lat = 0;
        for (int i = 0; i < 60; i++) begin
            start = (i < hold);
            rd1   = rd1 ^ 32'hA5A5_0F0F;
            rd2   = rd2 + 32'd3;
            if (i < hold) begin
                #3;
                chk("stall_start_busy", {63'd0, stall}, 64'd1);
            end
            @(posedge clock); #1;
            lat++;
            if (done) break;
        end
        start = 1'b0;
    endtask

    task automatic to_idle();
        @(posedge clock); #1;
    endtask

    task automatic run_vec(input string name, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi,
                           input logic [31:0] elo, input int hold);
        int lat;
        launch(o, a, b);
        wait_done(hold, lat);
        chk({name, "_lat"}, 64'(lat), 64'd33);
        chk({name, "_hi"}, {32'd0, Hi}, {32'd0, ehi});
        chk({name, "_lo"}, {32'd0, Lo}, {32'd0, elo});
        to_idle();
    endtask

    initial begin
        int lat;
        chk("ref_mult",  ref_result(MD_MULT, 32'hFFFF_FFFD, 32'd5), 64'hFFFF_FFFF_FFFF_FFF1);
        chk("ref_div",   ref_result(MD_DIV, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("ref_divu0", ref_result(MD_DIVU, 32'h64, 32'd0), 64'h0000_0064_FFFF_FFFF);

        repeat (2) @(posedge clock);
        #1;
        chk("rst_hi",    {32'd0, Hi}, 64'd0);
        chk("rst_lo",    {32'd0, Lo}, 64'd0);
        chk("rst_busy",  {63'd0, busy}, 64'd0);
        chk("rst_done",  {63'd0, done}, 64'd0);
        chk("rst_stall", {63'd0, stall}, 64'd0);
        reset_n = 1'b1;

        // First start right after reset release.
        run_vec("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_vec("mult_neg",  MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
        run_vec("div_neg",   MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_vec("div_ovf",   MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
        run_vec("divu_zero", MD_DIVU,  32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 0);
        run_vec("div_zero",  MD_DIV,   32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF, 0);
        run_vec("div_rneg",  MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
        run_vec("divu_big",  MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0000, 32'h5555_5555, 0);
        run_vec("multu_mix", MD_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080, 0);

        // mthi and mfhi while busy are held off; result wins.
        launch(MD_MULTU, 32'd2, 32'd3);
        hilo_we  = 1'b1;
        hilo_sel = 1'b1;
        hilo_rd  = 1'b1;
        rd1      = 32'h1234_5678;
        #3;
        chk("mthi_busy_stall", {63'd0, stall}, 64'd1);
        @(posedge clock); #1;
        hilo_we = 1'b0;
        hilo_rd = 1'b0;
        wait_done(0, lat);
        chk("mthi_busy_lat", 64'(lat), 64'd32);
        chk("mthi_busy_hi", {32'd0, Hi}, 64'd0);
        chk("mthi_busy_lo", {32'd0, Lo}, 64'd6);
        to_idle();

        // mtlo in IDLE lands on the next edge.
        hilo_we  = 1'b1;
        hilo_sel = 1'b0;
        rd1      = 32'h0000_ABCD;
        @(posedge clock); #1;
        hilo_we = 1'b0;
        chk("mtlo_idle", {32'd0, Lo}, 64'h0000_ABCD);

        // mtlo together with start: write happens now, result overwrites later.
        hilo_we = 1'b1;
        launch(MD_MULT, 32'd7, 32'hFFFF_FFFA);
        hilo_we = 1'b0;
        chk("mtlo_start_lo", {32'd0, Lo}, 64'd7);
        wait_done(0, lat);
        chk("mtlo_start_hi_res", {32'd0, Hi}, 64'hFFFF_FFFF);
        chk("mtlo_start_lo_res", {32'd0, Lo}, 64'hFFFF_FFD6);
        to_idle();

        // Reset mid-operation abandons the result.
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        repeat (10) begin
            @(posedge clock); #1;
        end
        reset_n = 1'b0;
        #3;
        chk("midrst_busy", {63'd0, busy}, 64'd0);
        chk("midrst_done", {63'd0, done}, 64'd0);
        chk("midrst_hi",   {32'd0, Hi}, 64'd0);
        chk("midrst_lo",   {32'd0, Lo}, 64'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        run_vec("after_rst", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0);

        repeat (3) @(posedge clock);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
